// File: rtl/prog_ram_arbiter.sv
// prog_ram_arbiter: shares the single-port program RAM between the CPU fetch
// port (read-only) and the program loader port (read/write).
// Optional feature macro: PROG_RAM_ARB_RR_EN selects round-robin arbitration
// on contention; when undefined the loader always wins contention.
module prog_ram_arbiter #(
  parameter int unsigned AW = 10,
  parameter int unsigned DW = 32
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic [AW-1:0] cpu_addr,
  output logic          cpu_gnt,
  output logic          cpu_stall,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          ld_req,
  input  logic          ld_we,
  input  logic          ld_lock,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_wdata,
  output logic          ld_gnt,
  output logic          ld_rvalid,
  output logic [DW-1:0] ld_rdata,
  output logic [AW-1:0] ram_address,
  output logic [DW-1:0] ram_data,
  output logic          ram_wren,
  input  logic [DW-1:0] ram_q
);

  typedef enum logic {
    LK_FREE = 1'b0,
    LK_HELD = 1'b1
  } lock_state_t;

  lock_state_t   lock_q;
  lock_state_t   lock_d;
  logic          locked;
  logic          cpu_ok;
  logic          ld_ok;
  logic          contend;
  logic [AW-1:0] hold_addr_q;
  logic [1:0]    rd_tag_q;

  assign locked = (lock_q == LK_HELD);

  // Lock state register: a loader burst keeps the CPU off the RAM.
  always_ff @(posedge clock) begin
    if (reset) begin
      lock_q <= LK_FREE;
    end else begin
      lock_q <= lock_d;
    end
  end

  // Lock next state: dropping ld_lock always releases; a locked grant takes it.
  always_comb begin
    lock_d = lock_q;
    if (!ld_lock) begin
      lock_d = LK_FREE;
    end else if (ld_gnt) begin
      lock_d = LK_HELD;
    end
  end

`ifdef PROG_RAM_ARB_RR_EN
  logic rr_cpu_q;

  // Round-robin pointer: flips to the loser after every contended cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      rr_cpu_q <= 1'b1;
    end else if (contend) begin
      rr_cpu_q <= ~rr_cpu_q;
    end
  end
`endif

  // Grant selection from the current requests; nothing is granted in reset.
  always_comb begin
    cpu_gnt = 1'b0;
    ld_gnt  = 1'b0;
    cpu_ok  = cpu_req & ~locked & ~reset;
    ld_ok   = ld_req & ~reset;
    contend = cpu_ok & ld_ok;
    if (contend) begin
`ifdef PROG_RAM_ARB_RR_EN
      cpu_gnt = rr_cpu_q;
      ld_gnt  = ~rr_cpu_q;
`else
      ld_gnt  = 1'b1;
`endif
    end else begin
      cpu_gnt = cpu_ok;
      ld_gnt  = ld_ok;
    end
  end

  assign cpu_stall = cpu_req & ~cpu_gnt;

  // Held address: the RAM keeps seeing the last granted address when idle.
  always_ff @(posedge clock) begin
    if (reset) begin
      hold_addr_q <= AW'(0);
    end else if (cpu_gnt) begin
      hold_addr_q <= cpu_addr;
    end else if (ld_gnt) begin
      hold_addr_q <= ld_addr;
    end
  end

  // RAM-side mux.
  always_comb begin
    ram_address = hold_addr_q;
    if (cpu_gnt) begin
      ram_address = cpu_addr;
    end else if (ld_gnt) begin
      ram_address = ld_addr;
    end
  end

  assign ram_data = ld_wdata;
  assign ram_wren = ld_gnt & ld_we & ~reset;

  // Read tag: remembers which port owns the data returning next cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_tag_q <= 2'b00;
    end else begin
      rd_tag_q <= {cpu_gnt, ld_gnt & ~ld_we};
    end
  end

  // Reset arriving while a read is in flight swallows its valid pulse.
  assign cpu_rvalid = rd_tag_q[1] & ~reset;
  assign ld_rvalid  = rd_tag_q[0] & ~reset;
  assign cpu_rdata  = ram_q;
  assign ld_rdata   = ram_q;

  // Grants are mutually exclusive.
  always_ff @(posedge clock) begin
    if (!reset) begin
      assert (!(cpu_gnt && ld_gnt));
    end
  end

endmodule
